// File: rtl/dar_pkg.sv
// Shared types and constants for the router programming master.
package dar_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SEND,
      WAIT,
      CHECK,
      GAP
   } dar_state_e;

   localparam int   DAR_FRAME_BITS = 6;
   localparam int   DAR_GO_CYCLES  = 2;

   localparam logic PRGRM_IDLE_IN  = 1'b0;
   localparam logic PRGRM_IDLE_GO_ = 1'b1;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/dar_piso.sv
// Load/shift parallel-in serial-out register, MSB first, with bit index and last-bit flag.
module dar_piso
   import dar_pkg::*;
#(
   parameter int WIDTH = DAR_FRAME_BITS,
   parameter int CNT_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             shift,
   input  logic [WIDTH-1:0] data,
   output logic             ser,
   output logic [CNT_W-1:0] bit_idx,
   output logic             last
);

   logic [WIDTH-1:0] sreg;

   // Idle level is shifted in, so the line returns to idle after the last bit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sreg    <= '0;
         bit_idx <= '0;
      end else if (load) begin
         sreg    <= data;
         bit_idx <= '0;
      end else if (shift) begin
         sreg    <= {sreg[WIDTH-2:0], PRGRM_IDLE_IN};
         bit_idx <= bit_idx + CNT_W'(1);
      end
   end

   assign ser  = sreg[WIDTH-1];
   assign last = (bit_idx == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/dar_prgrm_tx.sv
// Serial programming master: frames a parallel word onto prgrm_in/prgrm_go_,
// samples err_ after each frame and retries a bounded number of times.
//   state | meaning
//   IDLE  | ready for a word, lines at idle levels
//   SEND  | shifting frame bits out, prgrm_go_ low for the leading bits
//   WAIT  | letting the router settle before err_ is sampled
//   CHECK | err_ sample cycle, decides done / retry / fail
//   GAP   | enforced idle spacing before the next frame or IDLE
module dar_prgrm_tx
   import dar_pkg::*;
#(
   parameter int FRAME_BITS = DAR_FRAME_BITS,
   parameter int GO_CYCLES  = DAR_GO_CYCLES,
   parameter int ERR_LAT    = 2,
   parameter int GAP_CYCLES = 4,
   parameter int MAX_RETRY  = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cfg_valid,
   output logic                  cfg_ready,
   input  logic [FRAME_BITS-1:0] cfg_data,
   output logic                  prgrm_in,
   output logic                  prgrm_go_,
   input  logic                  err_,
   output logic                  done,
   output logic                  fail,
   output logic                  busy
);

   localparam int CNT_W = $clog2(max3(FRAME_BITS, ERR_LAT, GAP_CYCLES) + 1);
   localparam int RTY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

   localparam logic [CNT_W-1:0] GO_LIM  = CNT_W'(GO_CYCLES);
   localparam logic [CNT_W-1:0] WAIT_LD = CNT_W'((ERR_LAT > 1) ? ERR_LAT - 2 : 0);
   localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'(GAP_CYCLES - 1);
   localparam logic [RTY_W-1:0] RTY_MAX = RTY_W'(MAX_RETRY);

   dar_state_e            state;
   logic [FRAME_BITS-1:0] word;
   logic [CNT_W-1:0]      tmr;
   logic [RTY_W-1:0]      rty;
   logic                  retry_pend;

   logic                  piso_load;
   logic                  piso_shift;
   logic [FRAME_BITS-1:0] piso_data;
   logic [CNT_W-1:0]      bit_idx;
   logic [CNT_W-1:0]      next_idx;
   logic                  last_bit;

   assign piso_load  = (state == IDLE && cfg_valid && cfg_ready) ||
                       (state == GAP && tmr == '0 && retry_pend);
   assign piso_data  = (state == IDLE) ? cfg_data : word;
   assign piso_shift = (state == SEND);
   assign next_idx   = bit_idx + CNT_W'(1);

   dar_piso #(
      .WIDTH (FRAME_BITS),
      .CNT_W (CNT_W)
   ) u_piso (
      .clk     (clk),
      .rst     (rst),
      .load    (piso_load),
      .shift   (piso_shift),
      .data    (piso_data),
      .ser     (prgrm_in),
      .bit_idx (bit_idx),
      .last    (last_bit)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         word       <= '0;
         tmr        <= '0;
         rty        <= '0;
         retry_pend <= 1'b0;
         prgrm_go_  <= PRGRM_IDLE_GO_;
         cfg_ready  <= 1'b1;
         done       <= 1'b0;
         fail       <= 1'b0;
         busy       <= 1'b0;
      end else begin
         done <= 1'b0;
         fail <= 1'b0;
         case (state)
            IDLE: begin
               if (cfg_valid && cfg_ready) begin
                  word       <= cfg_data;
                  rty        <= '0;
                  retry_pend <= 1'b0;
                  prgrm_go_  <= 1'b0;
                  cfg_ready  <= 1'b0;
                  busy       <= 1'b1;
                  state      <= SEND;
               end
            end
            SEND: begin
               prgrm_go_ <= !(next_idx < GO_LIM);
               if (last_bit) begin
                  prgrm_go_ <= PRGRM_IDLE_GO_;
                  if (ERR_LAT > 1) begin
                     tmr   <= WAIT_LD;
                     state <= WAIT;
                  end else begin
                     state <= CHECK;
                  end
               end
            end
            WAIT: begin
               if (tmr == '0) state <= CHECK;
               else           tmr   <= tmr - CNT_W'(1);
            end
            CHECK: begin
               tmr   <= GAP_LD;
               state <= GAP;
               if (err_) begin
                  done       <= 1'b1;
                  retry_pend <= 1'b0;
               end else if (rty < RTY_MAX) begin
                  rty        <= rty + RTY_W'(1);
                  retry_pend <= 1'b1;
               end else begin
                  fail       <= 1'b1;
                  retry_pend <= 1'b0;
               end
            end
            GAP: begin
               if (tmr != '0) begin
                  tmr <= tmr - CNT_W'(1);
               end else if (retry_pend) begin
                  prgrm_go_ <= 1'b0;
                  state     <= SEND;
               end else begin
                  cfg_ready <= 1'b1;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dar_prgrm_tx.sv
// Randomised directed bench for dar_prgrm_tx against a frame-timing reference model.
module tb_dar_prgrm_tx;

   localparam int FB    = 6;
   localparam int GO    = 2;
   localparam int LAT   = 2;
   localparam int GAPC  = 4;
   localparam int MAXR  = 3;
   localparam int P     = FB + LAT + GAPC;   // cycles from one frame start to the next
   localparam int SMP_I = FB + LAT - 1;      // frame-relative err_ sample cycle
   localparam int RES_I = FB + LAT;          // frame-relative done/fail cycle

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          cfg_valid = 1'b0;
   logic          cfg_ready;
   logic [FB-1:0] cfg_data = '0;
   logic          prgrm_in;
   logic          prgrm_go_;
   logic          err_ = 1'b1;
   logic          done;
   logic          fail;
   logic          busy;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int hs_cyc = 0;
   int prev_hs = 0;
   int done_cnt = 0;
   int fail_cnt = 0;

   dar_prgrm_tx dut (
      .clk       (clk),
      .rst       (rst),
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .cfg_data  (cfg_data),
      .prgrm_in  (prgrm_in),
      .prgrm_go_ (prgrm_go_),
      .err_      (err_),
      .done      (done),
      .fail      (fail),
      .busy      (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Protocol monitors, sampled mid-cycle
   logic done_q = 1'b0;
   logic fail_q = 1'b0;
   int   go_run = 0;
   always @(negedge clk) begin
      if (rst) begin
         go_run = 0;
         done_q = 1'b0;
         fail_q = 1'b0;
      end else begin
         if (done) done_cnt++;
         if (fail) fail_cnt++;
         if (done || fail) chk("done_fail_excl", {7'd0, done && fail}, 8'd0);
         if (done_q || fail_q) chk("pulse_width", {6'd0, done && done_q, fail && fail_q}, 8'd0);
         if (cfg_ready || busy) chk("ready_busy_excl", {7'd0, cfg_ready && busy}, 8'd0);
         if (!prgrm_go_) go_run++;
         else begin
            if (go_run != 0) chk("go_run_len", 8'(go_run), 8'(GO));
            go_run = 0;
         end
         done_q = done;
         fail_q = fail;
      end
   end

   // Offers word w, answers err_=0 at the first nfail sample points, and checks
   // every cycle of the resulting frames against the model. Entered and left at a negedge.
   task automatic xfer(input logic [FB-1:0] w, input int nfail);
      int  nfr;
      int  total;
      int  f;
      int  i;
      bit  ok;
      logic exp_in;
      nfr   = (nfail > MAXR) ? MAXR + 1 : nfail + 1;
      ok    = (nfail <= MAXR);
      total = nfr * P;
      chk("ready_at_offer", {7'd0, cfg_ready}, 8'd1);
      cfg_valid = 1'b1;
      cfg_data  = w;
      err_      = 1'($urandom);
      @(posedge clk);
      prev_hs = hs_cyc;
      hs_cyc  = cyc;
      for (int c = 1; c <= total + 1; c++) begin
         @(negedge clk);
         f = (c - 1) / P;
         i = (c - 1) % P;
         if (c <= total) begin
            exp_in = (i < FB) ? w[FB-1-i] : 1'b0;
            chk("prgrm_in", {7'd0, prgrm_in}, {7'd0, exp_in});
            chk("prgrm_go_", {7'd0, prgrm_go_}, {7'd0, !(i < GO)});
            chk("done", {7'd0, done}, {7'd0, (i == RES_I) && (f == nfr - 1) && ok});
            chk("fail", {7'd0, fail}, {7'd0, (i == RES_I) && (f == nfr - 1) && !ok});
            chk("busy", {7'd0, busy}, 8'd1);
            chk("cfg_ready_busy", {7'd0, cfg_ready}, 8'd0);
            cfg_valid = 1'($urandom);
            cfg_data  = FB'($urandom);
            err_      = (i == SMP_I) ? (f >= nfail) : 1'($urandom);
         end else begin
            chk("idle_in", {7'd0, prgrm_in}, 8'd0);
            chk("idle_go_", {7'd0, prgrm_go_}, 8'd1);
            chk("idle_ready", {7'd0, cfg_ready}, 8'd1);
            chk("idle_busy", {7'd0, busy}, 8'd0);
            chk("idle_pulses", {6'd0, done, fail}, 8'd0);
            cfg_valid = 1'b0;
            err_      = 1'b1;
         end
      end
   endtask

   initial begin
      int d0;
      int f0;
      logic [FB-1:0] w;

      @(negedge clk);
      chk("rst_in", {7'd0, prgrm_in}, 8'd0);
      chk("rst_go_", {7'd0, prgrm_go_}, 8'd1);
      chk("rst_ready", {7'd0, cfg_ready}, 8'd1);
      chk("rst_done", {7'd0, done}, 8'd0);
      chk("rst_fail", {7'd0, fail}, 8'd0);
      chk("rst_busy", {7'd0, busy}, 8'd0);
      rst = 1'b0;
      @(negedge clk);

      // Clean frame, single retry, and retries exhausted
      d0 = done_cnt; f0 = fail_cnt;
      xfer(6'b100111, 0);
      chk("clean_done_cnt", 8'(done_cnt - d0), 8'd1);
      d0 = done_cnt; f0 = fail_cnt;
      xfer(6'b100111, 1);
      chk("retry1_done_cnt", 8'(done_cnt - d0), 8'd1);
      chk("retry1_fail_cnt", 8'(fail_cnt - f0), 8'd0);
      d0 = done_cnt; f0 = fail_cnt;
      xfer(6'b100111, 99);
      chk("exhaust_done_cnt", 8'(done_cnt - d0), 8'd0);
      chk("exhaust_fail_cnt", 8'(fail_cnt - f0), 8'd1);

      // Back-to-back words with valid held high
      xfer(6'h3F, 0);
      xfer(6'h01, 0);
      chk("b2b_spacing_ok", {7'd0, (hs_cyc - prev_hs) >= (FB + LAT + 1 + GAPC)}, 8'd1);

      // Reset on the third bit of a frame
      d0 = done_cnt; f0 = fail_cnt;
      cfg_valid = 1'b1;
      cfg_data  = 6'b101101;
      @(posedge clk);
      @(negedge clk);
      cfg_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("pre_rst_bit3", {7'd0, prgrm_in}, 8'd1);
      #1 rst = 1'b1;
      #1;
      chk("midrst_go_", {7'd0, prgrm_go_}, 8'd1);
      chk("midrst_in", {7'd0, prgrm_in}, 8'd0);
      chk("midrst_busy", {7'd0, busy}, 8'd0);
      chk("midrst_ready", {7'd0, cfg_ready}, 8'd1);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("midrst_no_pulse", {6'd0, done_cnt != d0, fail_cnt != f0}, 8'd0);
      xfer(6'b011010, 0);

      // Random words and error patterns
      for (int n = 0; n < 8; n++) begin
         w = FB'($urandom);
         xfer(w, int'($urandom_range(0, 5)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
